mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath. It sits directly downstream of the register file and takes register-file read ports 1 and 2 as its operands. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the result in HI/LO for later MFHI/MFLO reads. It is the first stateful, multi-cycle consumer of register-file data.

## Interface
- No parameters; width fixed at 32 bits.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request; sampled only in IDLE.
- op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved.
- operand_a  in  32  rs value (register-file read_data_1); dividend / multiplicand / MTHI/MTLO source.
- operand_b  in  32  rt value (register-file read_data_2); divisor / multiplier.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; HI/LO are final while it is high.

## Operation
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
- States: IDLE → CALC → SIGN → IDLE.
- Accept: an edge with state=IDLE, start=1 and a valid op.
  - Reserved op, or start while busy: ignored, no state change, no done.
- On accept of MULT/MULTU/DIV/DIVU:
  - Latch op.
  - Signed ops: latch |operand_a|, |operand_b| and the two sign bits. abs(0x80000000) = 0x80000000 as an unsigned value.
  - Unsigned ops: latch operands unchanged.
  - Set counter=31; go to CALC.
- CALC, multiply: 32 iterations of shift-add into a 64-bit product, one per edge.
- CALC, divide: 32 iterations of restoring shift-subtract, one per edge.
  - Remainder datapath is 33 bits to absorb the borrow.
- CALC → SIGN on the edge where counter=0.
- SIGN (one cycle): write hi/lo and go to IDLE, with done=1 on that same edge.
  - MULT: product negated (64-bit two's complement) when the operand signs differ.
  - DIV: quotient negated when the signs differ; remainder takes the dividend's sign.
- Divide by zero (DIV or DIVU): lo=0xFFFFFFFF, hi=original operand_a (sign restored). No exception.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the unsigned core; no special case is needed.
- MTHI/MTLO: on the accept edge write hi (or lo) ← operand_a, leave the other register unchanged, and pulse done on the next cycle. busy stays 0.
- hi/lo change only at the SIGN edge, an MTHI/MTLO accept edge, or reset. They hold their value during CALC.

## Timing
- Multiply/divide latency: accept at edge E0, CALC at edges E1–E32, SIGN edge E33.
  - hi/lo valid and done=1 during the cycle after E33.
  - busy is high for the cycles following E0..E32 (33 cycles).
- Back-to-back: start may be reasserted in the cycle where done=1 (state is already IDLE). It is accepted on the next edge, giving zero dead cycles.
- Operands are sampled only on the accept edge. Later changes on read_data_* have no effect.
- Reset mid-operation: asynchronous abort. The result is discarded, hi=lo=0, and no done is produced.
- done and busy are never both high.

## Structure
- Shared package `mips_pkg` holds:
  - the op encodings (MDU_MULT … MDU_MTLO)
  - the state encoding (IDLE, CALC, SIGN)
  - the width constant (32).
- One sub-module: `mdu_iter_core`. It holds the unsigned 32-step shift-add/shift-subtract datapath and counter.
- Sign handling, HI/LO registers and the FSM stay in `mult_div_unit`.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=5 → after 34 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=0x00000064.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles → hi/lo updated on the accept edges, busy never high, two done pulses.
- Start DIVU 50/7, assert start with MULT at cycle 10 (ignored), assert reset at cycle 20 → hi=lo=0 immediately, no done. After reset, DIVU 50/7 completes with lo=7, hi=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS datapath: multiply/divide op codes, MDU FSM states and
// the datapath width.
package mips_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StSign = 2'd2
  } mdu_state_e;

  function automatic logic mdu_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the register-file read ports and the multiply/divide unit.
interface mult_div_unit_if;
  import mips_pkg::*;

  logic                 start;
  logic [2:0]           op;
  logic [MDU_WIDTH-1:0] operand_a;
  logic [MDU_WIDTH-1:0] operand_b;
  logic [MDU_WIDTH-1:0] hi;
  logic [MDU_WIDTH-1:0] lo;
  logic                 busy;
  logic                 done;

  modport master (
    output start, op, operand_a, operand_b,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output hi, lo, busy, done
  );

endinterface

// File: rtl/mdu_iter_core.sv
// Unsigned 32-step iterative core: shift-add multiply or restoring shift-subtract divide.
// Multiply leaves the product in {o_hi, o_lo}; divide leaves remainder in o_hi, quotient in o_lo.
module mdu_iter_core
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic                 i_is_div,
  input  logic [MDU_WIDTH-1:0] i_a,
  input  logic [MDU_WIDTH-1:0] i_b,
  output logic [MDU_WIDTH-1:0] o_hi,
  output logic [MDU_WIDTH-1:0] o_lo,
  output logic                 o_last
);

  logic [MDU_WIDTH-1:0] r_acc;
  logic [MDU_WIDTH-1:0] r_low;
  logic [MDU_WIDTH-1:0] r_opnd;
  logic [4:0]           r_cnt;
  logic                 r_is_div;

  logic [MDU_WIDTH:0]   w_sum;
  logic [MDU_WIDTH:0]   w_shift;
  logic [MDU_WIDTH:0]   w_diff;

  always_comb begin
    w_sum   = {1'b0, r_acc} + (r_low[0] ? {1'b0, r_opnd} : '0);
    w_shift = {r_acc, r_low[MDU_WIDTH-1]};
    // Borrow lands in bit 32; a non-negative difference always fits back into 32 bits.
    w_diff  = w_shift - {1'b0, r_opnd};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_low    <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_low    <= i_is_div ? i_a : i_b;
      r_opnd   <= i_is_div ? i_b : i_a;
      r_cnt    <= 5'd31;
      r_is_div <= i_is_div;
    end else if (i_step) begin
      if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
      if (r_is_div) begin
        if (!w_diff[MDU_WIDTH]) begin
          r_acc <= w_diff[MDU_WIDTH-1:0];
          r_low <= {r_low[MDU_WIDTH-2:0], 1'b1};
        end else begin
          r_acc <= w_shift[MDU_WIDTH-1:0];
          r_low <= {r_low[MDU_WIDTH-2:0], 1'b0};
        end
      end else begin
        r_acc <= w_sum[MDU_WIDTH:1];
        r_low <= {w_sum[0], r_low[MDU_WIDTH-1:1]};
      end
    end
  end

  assign o_hi   = r_acc;
  assign o_lo   = r_low;
  assign o_last = (r_cnt == 5'd0);

endmodule

// File: rtl/mult_div_unit.sv
// Multiply/divide unit with architectural HI/LO: sign handling, FSM and HI/LO registers
// around the unsigned iterative core.
module mult_div_unit
  import mips_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  mdu_state_e r_state, w_state_next;

  logic                 r_is_div;
  logic                 r_sign_a;
  logic                 r_sign_b;
  logic                 r_b_zero;
  logic [MDU_WIDTH-1:0] r_hi;
  logic [MDU_WIDTH-1:0] r_lo;
  logic                 r_done;

  logic                   w_accept;
  logic                   w_is_muldiv;
  logic                   w_load;
  logic                   w_signed_op;
  logic [MDU_WIDTH-1:0]   w_abs_a;
  logic [MDU_WIDTH-1:0]   w_abs_b;
  logic [MDU_WIDTH-1:0]   w_core_hi;
  logic [MDU_WIDTH-1:0]   w_core_lo;
  logic                   w_core_last;
  logic                   w_neg;
  logic [2*MDU_WIDTH-1:0] w_prod;
  logic [MDU_WIDTH-1:0]   w_res_hi;
  logic [MDU_WIDTH-1:0]   w_res_lo;

  always_comb begin
    w_accept    = (r_state == StIdle) && bus.start && (bus.op <= MDU_MTLO);
    w_is_muldiv = (bus.op < MDU_MTHI);
    w_load      = w_accept && w_is_muldiv;
    w_signed_op = mdu_is_signed(bus.op);
    // abs(0x80000000) wraps to itself, which is the correct unsigned magnitude.
    w_abs_a = (w_signed_op && bus.operand_a[MDU_WIDTH-1]) ? (~bus.operand_a + 1'b1)
                                                          : bus.operand_a;
    w_abs_b = (w_signed_op && bus.operand_b[MDU_WIDTH-1]) ? (~bus.operand_b + 1'b1)
                                                          : bus.operand_b;
  end

  mdu_iter_core u_core (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_step   (r_state == StCalc),
    .i_is_div (mdu_is_div(bus.op)),
    .i_a      (w_abs_a),
    .i_b      (w_abs_b),
    .o_hi     (w_core_hi),
    .o_lo     (w_core_lo),
    .o_last   (w_core_last)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_load) w_state_next = StCalc;
      StCalc:  if (w_core_last) w_state_next = StSign;
      StSign:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_neg  = r_sign_a ^ r_sign_b;
    w_prod = {w_core_hi, w_core_lo};
    if (w_neg) w_prod = ~w_prod + 1'b1;
    if (r_is_div) begin
      // Divide by zero: quotient is all ones regardless of sign; remainder rebuilds operand_a.
      if (r_b_zero)   w_res_lo = '1;
      else if (w_neg) w_res_lo = ~w_core_lo + 1'b1;
      else            w_res_lo = w_core_lo;
      w_res_hi = r_sign_a ? (~w_core_hi + 1'b1) : w_core_hi;
    end else begin
      w_res_hi = w_prod[2*MDU_WIDTH-1:MDU_WIDTH];
      w_res_lo = w_prod[MDU_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_is_div <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_b_zero <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == StSign) || (w_accept && !w_is_muldiv);
      if (w_load) begin
        r_is_div <= mdu_is_div(bus.op);
        r_sign_a <= w_signed_op && bus.operand_a[MDU_WIDTH-1];
        r_sign_b <= w_signed_op && bus.operand_b[MDU_WIDTH-1];
        r_b_zero <= (bus.operand_b == '0);
      end
      if (r_state == StSign) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (w_accept && (bus.op == MDU_MTHI)) begin
        r_hi <= bus.operand_a;
      end else if (w_accept && (bus.op == MDU_MTLO)) begin
        r_lo <= bus.operand_a;
      end
    end
  end

  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign bus.busy = (r_state != StIdle);
  assign bus.done = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table through a scoreboard, plus MTHI/MTLO,
// reserved-op and reset-abort sequences.
module tb_mult_div_unit;
  import mips_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  vec_t vecs[12];

  always #5 clk = ~clk;

  mult_div_unit_if mdu_if ();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mdu_if.slave)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge where done is seen (or on timeout).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string tag);
    exp_t        e;
    int          cyc;
    int          busy_cyc;
    logic        seen;
    logic        held;
    logic        overlap;
    logic [31:0] hi0;
    logic [31:0] lo0;
    e.hi = eh;
    e.lo = el;
    sb.push_back(e);
    hi0 = mdu_if.hi;
    lo0 = mdu_if.lo;
    mdu_if.start     = 1'b1;
    mdu_if.op        = op;
    mdu_if.operand_a = a;
    mdu_if.operand_b = b;
    @(posedge clk);
    #1;
    mdu_if.start     = 1'b0;
    mdu_if.op        = MDU_MULTU;
    mdu_if.operand_a = ~a;
    mdu_if.operand_b = a ^ b ^ 32'h5a5a_a5a5;
    seen     = 1'b0;
    held     = 1'b1;
    overlap  = 1'b0;
    cyc      = 0;
    busy_cyc = 0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (mdu_if.busy) busy_cyc++;
      if (mdu_if.busy && mdu_if.done) overlap = 1'b1;
      if (!mdu_if.done && (mdu_if.hi !== hi0 || mdu_if.lo !== lo0)) held = 1'b0;
      if (mdu_if.done) seen = 1'b1;
    end
    e = sb.pop_front();
    check({tag, " done seen"}, {63'd0, seen}, 64'd1);
    if (seen) begin
      check({tag, " hi"}, {32'd0, mdu_if.hi}, {32'd0, e.hi});
      check({tag, " lo"}, {32'd0, mdu_if.lo}, {32'd0, e.lo});
      check({tag, " latency"}, 64'(cyc), 64'd34);
      check({tag, " busy cycles"}, 64'(busy_cyc), 64'd33);
      check({tag, " hi/lo held"}, {63'd0, held}, 64'd1);
      check({tag, " busy&done"}, {63'd0, overlap}, 64'd0);
    end
  endtask

  initial begin
    int done_cnt;

    vecs[0]  = '{MDU_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{MDU_DIVU,  32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF};
    vecs[3]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{MDU_DIVU,  32'd50,        32'd7,        32'd1,         32'd7};
    vecs[6]  = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[7]  = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[9]  = '{MDU_MULTU, 32'h1234_5678, 32'h10,       32'h0000_0001, 32'h2345_6780};
    vecs[10] = '{MDU_MULT,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2};
    vecs[11] = '{MDU_DIVU,  32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 32'h0FFF_FFFF};

    reset            = 1'b1;
    mdu_if.start     = 1'b0;
    mdu_if.op        = MDU_MULT;
    mdu_if.operand_a = '0;
    mdu_if.operand_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset hi", {32'd0, mdu_if.hi}, 64'd0);
    check("reset lo", {32'd0, mdu_if.lo}, 64'd0);
    check("reset busy", {63'd0, mdu_if.busy}, 64'd0);
    check("reset done", {63'd0, mdu_if.done}, 64'd0);

    // Back-to-back: each op is issued in the done cycle of the previous one.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
             $sformatf("vec%0d", i));
    end

    // MTHI then MTLO on consecutive edges.
    mdu_if.start     = 1'b1;
    mdu_if.op        = MDU_MTHI;
    mdu_if.operand_a = 32'h1234_5678;
    done_cnt         = 0;
    @(posedge clk);
    #1;
    mdu_if.op        = MDU_MTLO;
    mdu_if.operand_a = 32'h9ABC_DEF0;
    @(negedge clk);
    if (mdu_if.done) done_cnt++;
    check("mthi hi", {32'd0, mdu_if.hi}, 64'h1234_5678);
    check("mthi lo kept", {32'd0, mdu_if.lo}, 64'h0FFF_FFFF);
    check("mthi busy", {63'd0, mdu_if.busy}, 64'd0);
    @(posedge clk);
    #1;
    mdu_if.start = 1'b0;
    @(negedge clk);
    if (mdu_if.done) done_cnt++;
    check("mtlo lo", {32'd0, mdu_if.lo}, 64'h9ABC_DEF0);
    check("mtlo hi kept", {32'd0, mdu_if.hi}, 64'h1234_5678);
    check("mtlo busy", {63'd0, mdu_if.busy}, 64'd0);
    @(negedge clk);
    if (mdu_if.done) done_cnt++;
    check("mthi/mtlo done pulses", 64'(done_cnt), 64'd2);

    // Reserved op is ignored.
    mdu_if.start     = 1'b1;
    mdu_if.op        = 3'd6;
    mdu_if.operand_a = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    mdu_if.start = 1'b0;
    @(negedge clk);
    check("reserved busy", {63'd0, mdu_if.busy}, 64'd0);
    check("reserved done", {63'd0, mdu_if.done}, 64'd0);
    check("reserved hi", {32'd0, mdu_if.hi}, 64'h1234_5678);
    check("reserved lo", {32'd0, mdu_if.lo}, 64'h9ABC_DEF0);

    // DIVU 50/7, ignored MULT at cycle 10, asynchronous reset at cycle 20.
    mdu_if.start     = 1'b1;
    mdu_if.op        = MDU_DIVU;
    mdu_if.operand_a = 32'd50;
    mdu_if.operand_b = 32'd7;
    @(posedge clk);
    #1;
    mdu_if.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    mdu_if.start     = 1'b1;
    mdu_if.op        = MDU_MULT;
    mdu_if.operand_a = 32'd3;
    mdu_if.operand_b = 32'd3;
    @(negedge clk);
    check("start while busy: busy", {63'd0, mdu_if.busy}, 64'd1);
    check("start while busy: done", {63'd0, mdu_if.done}, 64'd0);
    @(posedge clk);
    #1;
    mdu_if.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort hi", {32'd0, mdu_if.hi}, 64'd0);
    check("abort lo", {32'd0, mdu_if.lo}, 64'd0);
    check("abort busy", {63'd0, mdu_if.busy}, 64'd0);
    @(negedge clk);
    reset    = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (mdu_if.done) done_cnt++;
    end
    check("abort no done", 64'(done_cnt), 64'd0);
    run_op(MDU_DIVU, 32'd50, 32'd7, 32'd1, 32'd7, "post-reset divu");

    check("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
